// File: rtl/regfile_writer.sv
// Write-side front end for the register file: an in-order write-back
// queue with read-after-write bypass on both read ports.
module regfile_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_dest,
  input  logic [DW-1:0]            in_data,
  input  logic                     rf_stall,
  output logic                     WriteEnable,
  output logic [AW-1:0]            Destination,
  output logic [DW-1:0]            Din,
  input  logic [AW-1:0]            RegSource1,
  input  logic [AW-1:0]            RegSource2,
  input  logic [DW-1:0]            rf_src1,
  input  logic [DW-1:0]            rf_src2,
  output logic [DW-1:0]            Source1,
  output logic [DW-1:0]            Source2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] dest_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  assign in_ready    = (count_q != CW'(DEPTH));
  assign WriteEnable = (count_q != '0) && !rf_stall;
  assign push        = in_valid && in_ready;
  assign pop         = WriteEnable;
  assign Destination = dest_q[rd_ptr_q];
  assign Din         = data_q[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = ovf_q;

  // Next pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (in_valid & ~in_ready);
  end

  // State and storage; reset wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push) begin
        dest_q[wr_ptr_q] <= in_dest;
        data_q[wr_ptr_q] <= in_data;
      end
    end
  end

  // Bypass: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    Source1 = rf_src1;
    Source2 = rf_src2;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (dest_q[idx] == RegSource1) Source1 = data_q[idx];
        if (dest_q[idx] == RegSource2) Source2 = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: vector table, directed corner
// sequences and random traffic against a queue model.
module tb_regfile_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, rf_stall;
  logic [3:0]  in_dest, RegSource1, RegSource2, Destination;
  logic [31:0] in_data, rf_src1, rf_src2, Din, Source1, Source2;
  logic        WriteEnable, overflow;
  logic [2:0]  count;

  regfile_writer #(.DEPTH(4), .AW(4), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data),
    .rf_stall(rf_stall), .WriteEnable(WriteEnable),
    .Destination(Destination), .Din(Din),
    .RegSource1(RegSource1), .RegSource2(RegSource2),
    .rf_src1(rf_src1), .rf_src2(rf_src2),
    .Source1(Source1), .Source2(Source2),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t mq[$];
  ent_t wlog[$];
  bit   m_ovf;
  bit   m_known = 0;

  task automatic model_check();
    logic [31:0] e1, e2;
    if (!m_known) return;
    e1 = rf_src1;
    e2 = rf_src2;
    foreach (mq[i]) begin
      if (mq[i].d == RegSource1) e1 = mq[i].v;
      if (mq[i].d == RegSource2) e2 = mq[i].v;
    end
    chk("we", WriteEnable, (mq.size() != 0) && !rf_stall);
    chk("count", count, mq.size());
    chk("ready", in_ready, mq.size() != DEPTH);
    chk("ovf", overflow, m_ovf);
    chk("src1", Source1, e1);
    chk("src2", Source2, e2);
    if (mq.size() != 0) begin
      chk("dest", Destination, mq[0].d);
      chk("din", Din, mq[0].v);
    end
  endtask

  task automatic model_edge();
    int n;
    n = mq.size();
    if (rst) begin
      mq.delete();
      m_ovf   = 0;
      m_known = 1;
    end else if (m_known) begin
      if (n != 0 && !rf_stall) void'(mq.pop_front());
      if (in_valid && n != DEPTH) mq.push_back('{d: in_dest, v: in_data});
      if (in_valid && n == DEPTH) m_ovf = 1;
    end
  endtask

  task automatic pre(bit r, bit v, logic [3:0] d,
                     logic [31:0] x, bit st);
    rst        = r;
    in_valid   = v;
    in_dest    = d;
    in_data    = x;
    rf_stall   = st;
    RegSource1 = 4'($urandom_range(0, 3));
    RegSource2 = 4'($urandom_range(0, 3));
    rf_src1    = $urandom;
    rf_src2    = $urandom;
    #1;
    model_check();
    if (WriteEnable && !rst) wlog.push_back('{d: Destination, v: Din});
  endtask

  task automatic post();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(bit r, bit v, logic [3:0] d,
                     logic [31:0] x, bit st);
    pre(r, v, d, x, st);
    post();
  endtask

  typedef struct {
    bit r; bit v; logic [3:0] d; logic [31:0] x; bit st;
    logic [3:0] a1; logic [3:0] a2;
    logic [31:0] f1; logic [31:0] f2;
    bit c; bit we; int cnt; bit rdy; bit ov;
    logic [31:0] s1; logic [31:0] s2;
    bit hc; logic [3:0] hd; logic [31:0] hx;
  } vec_t;

  vec_t tv[12];

  initial begin
    tv[0]  = '{1,1,9,'h99,0,9,1,'h11111111,'h22222222,
               0,0,0,1,0,0,0,0,0,0};
    tv[1]  = '{1,1,9,'h99,0,9,1,'h11111111,'h22222222,
               1,0,0,1,0,'h11111111,'h22222222,1,0,0};
    tv[2]  = '{0,1,1,1,0,1,2,'h100,'h200,
               1,0,0,1,0,'h100,'h200,1,0,0};
    tv[3]  = '{0,1,2,2,0,1,2,'h100,'h200,
               1,1,1,1,0,1,'h200,1,1,1};
    tv[4]  = '{0,0,0,0,0,1,2,'h100,'h200,
               1,1,1,1,0,'h100,2,1,2,2};
    tv[5]  = '{0,0,0,0,0,1,2,'h100,'h200,
               1,0,0,1,0,'h100,'h200,0,0,0};
    tv[6]  = '{0,1,3,'hAAAA0000,1,3,4,'hDEADBEEF,'h44,
               1,0,0,1,0,'hDEADBEEF,'h44,0,0,0};
    tv[7]  = '{0,1,3,'hBBBB0000,1,3,4,'hDEADBEEF,'h44,
               1,0,1,1,0,'hAAAA0000,'h44,1,3,'hAAAA0000};
    tv[8]  = '{0,0,0,0,1,3,4,'hDEADBEEF,'h44,
               1,0,2,1,0,'hBBBB0000,'h44,1,3,'hAAAA0000};
    tv[9]  = '{0,0,0,0,0,3,4,'hDEADBEEF,'h44,
               1,1,2,1,0,'hBBBB0000,'h44,1,3,'hAAAA0000};
    tv[10] = '{0,0,0,0,0,3,4,'hDEADBEEF,'h44,
               1,1,1,1,0,'hBBBB0000,'h44,1,3,'hBBBB0000};
    tv[11] = '{0,0,0,0,0,3,4,'hDEADBEEF,'h44,
               1,0,0,1,0,'hDEADBEEF,'h44,0,0,0};

    // vector table
    foreach (tv[k]) begin
      rst        = tv[k].r;
      in_valid   = tv[k].v;
      in_dest    = tv[k].d;
      in_data    = tv[k].x;
      rf_stall   = tv[k].st;
      RegSource1 = tv[k].a1;
      RegSource2 = tv[k].a2;
      rf_src1    = tv[k].f1;
      rf_src2    = tv[k].f2;
      #1;
      if (tv[k].c) begin
        chk($sformatf("v%0d_we", k), WriteEnable, tv[k].we);
        chk($sformatf("v%0d_cnt", k), count, tv[k].cnt);
        chk($sformatf("v%0d_rdy", k), in_ready, tv[k].rdy);
        chk($sformatf("v%0d_ovf", k), overflow, tv[k].ov);
        chk($sformatf("v%0d_s1", k), Source1, tv[k].s1);
        chk($sformatf("v%0d_s2", k), Source2, tv[k].s2);
        if (tv[k].hc) begin
          chk($sformatf("v%0d_dst", k), Destination, tv[k].hd);
          chk($sformatf("v%0d_din", k), Din, tv[k].hx);
        end
      end
      post();
    end

    // full / overflow
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'(i + 1), 32'h100 + i, 1);
    pre(0, 1, 5, 32'h105, 1);
    chk("full_cnt", count, 4);
    chk("full_rdy", in_ready, 0);
    post();
    chk("ovf_set", overflow, 1);
    wlog.delete();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    chk("ovf_sticky", overflow, 1);
    chk("drain_n", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("drain_d", wlog[i].d, i + 1);
      chk("drain_x", wlog[i].v, 32'h100 + i);
    end

    // simultaneous push and pop at full
    cyc(1, 0, 0, 0, 1);
    wlog.delete();
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'(8 + i), 32'h8 + i, 1);
    pre(0, 1, 12, 32'hC, 0);
    chk("pp_we", WriteEnable, 1);
    chk("pp_rdy", in_ready, 0);
    post();
    chk("pp_cnt", count, 3);
    pre(0, 1, 13, 32'hD, 1);
    chk("pp_rdy2", in_ready, 1);
    post();
    chk("pp_cnt2", count, 4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    chk("pp_n", wlog.size(), 5);
    if (wlog.size() == 5) begin
      chk("pp_d0", wlog[0].d, 8);
      chk("pp_d3", wlog[3].d, 11);
      chk("pp_d4", wlog[4].d, 13);
      chk("pp_x4", wlog[4].v, 32'hD);
    end

    // reset mid-drain
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'(i + 1), 32'h30 + i, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    wlog.delete();
    pre(0, 0, 0, 0, 0);
    chk("rm_cnt", count, 0);
    chk("rm_we", WriteEnable, 0);
    post();
    pre(0, 1, 7, 32'h7, 0);
    chk("rm_we0", WriteEnable, 0);
    post();
    pre(0, 0, 0, 0, 0);
    chk("rm_we1", WriteEnable, 1);
    chk("rm_dst", Destination, 7);
    chk("rm_din", Din, 32'h7);
    post();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("rm_n", wlog.size(), 1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 59) == 0,
          $urandom_range(0, 9) < 7,
          4'($urandom_range(0, 3)),
          $urandom,
          $urandom_range(0, 9) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
